// File: rtl/vdc_video_timing_if.sv
// Position/strobe bus from the VDC raster timing generator to the RAM
// interface and the pixel stage.
interface vdc_video_timing_if;
  logic [7:0] col;
  logic [4:0] line;
  logic [7:0] row;
  logic       newCol;
  logic       endCol;
  logic       newLine;
  logic       newRow;
  logic [1:0] newFrame;
  logic [1:0] visible;
  logic       hsync;
  logic       vsync;

  modport master (
    output col, line, row, newCol, endCol, newLine, newRow,
           newFrame, visible, hsync, vsync
  );

  modport slave (
    input  col, line, row, newCol, endCol, newLine, newRow,
           newFrame, visible, hsync, vsync
  );
endinterface

// File: rtl/vdc_video_timing.sv
// VDC raster timing generator: dot/column/scanline/row counters driven by
// the CRTC registers, with hsync/vsync countdowns and the position/strobe bus.
module vdc_video_timing #(
  parameter bit FIELD_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] reg_ht,
  input  logic [7:0] reg_hd,
  input  logic [7:0] reg_hsp,
  input  logic [3:0] reg_hsw,
  input  logic [3:0] reg_vsw,
  input  logic [7:0] reg_vt,
  input  logic [4:0] reg_va,
  input  logic [7:0] reg_vd,
  input  logic [7:0] reg_vsp,
  input  logic [1:0] reg_im,
  input  logic [4:0] reg_ctv,
  input  logic [3:0] reg_cth,
  vdc_video_timing_if.master bus
);

  typedef enum logic {V_ACTIVE, V_ADJUST} v_state_t;

  v_state_t   state, state_n;
  logic [3:0] dot, dot_n;
  logic       field, field_n;
  logic       started, started_n;
  logic [3:0] hs_cnt, hs_cnt_n;
  logic [3:0] vs_cnt, vs_cnt_n;

  logic [7:0] col_n, row_n;
  logic [4:0] line_n;
  logic       new_col_n, end_col_n, new_line_n, new_row_n;
  logic [1:0] new_frame_n, visible_n;
  logic       hsync_n, vsync_n;

  logic       col_adv, line_adv, wrap, frame_start;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    dot_n       = dot;
    field_n     = field;
    started_n   = started;
    hs_cnt_n    = hs_cnt;
    vs_cnt_n    = vs_cnt;
    col_n       = bus.col;
    line_n      = bus.line;
    row_n       = bus.row;
    hsync_n     = bus.hsync;
    vsync_n     = bus.vsync;
    new_row_n   = 1'b0;
    col_adv     = 1'b0;
    line_adv    = 1'b0;
    wrap        = 1'b0;
    frame_start = 1'b0;

    if (!started) begin
      // First enable after reset: load the origin as if every counter just wrapped.
      dot_n       = '0;
      col_n       = '0;
      line_n      = '0;
      row_n       = '0;
      state_n     = V_ACTIVE;
      started_n   = 1'b1;
      col_adv     = 1'b1;
      line_adv    = 1'b1;
      new_row_n   = 1'b1;
      frame_start = 1'b1;
    end else begin
      if (dot >= reg_cth) begin
        dot_n   = '0;
        col_adv = 1'b1;
      end else begin
        dot_n = dot + 4'd1;
      end

      if (col_adv) begin
        if (bus.col >= reg_ht) begin
          col_n    = '0;
          line_adv = 1'b1;
        end else begin
          col_n = bus.col + 8'd1;
        end
      end

      if (line_adv) begin
        case (state)
          V_ACTIVE: begin
            if (bus.line >= reg_ctv) begin
              line_n = '0;
              if (bus.row >= reg_vt) begin
                if (reg_va != 5'd0) begin
                  state_n = V_ADJUST;
                  row_n   = reg_vt + 8'd1;
                end else begin
                  wrap = 1'b1;
                end
              end else begin
                row_n     = bus.row + 8'd1;
                new_row_n = 1'b1;
              end
            end else begin
              line_n = bus.line + 5'd1;
            end
          end
          V_ADJUST: begin
            if (bus.line >= 5'(reg_va - 5'd1)) wrap = 1'b1;
            else                               line_n = bus.line + 5'd1;
          end
          default: state_n = V_ACTIVE;
        endcase
      end

      if (wrap) begin
        row_n       = '0;
        line_n      = '0;
        state_n     = V_ACTIVE;
        new_row_n   = 1'b1;
        frame_start = 1'b1;
        if (reg_im[0]) field_n = ~field;
      end
    end

    // Sync countdowns hold (width - 1); a fresh start always reloads.
    if (col_adv && col_n == reg_hsp) begin
      hsync_n  = 1'b1;
      hs_cnt_n = reg_hsw - 4'd1;
    end else if (col_adv && bus.hsync) begin
      if (hs_cnt == 4'd0) hsync_n = 1'b0;
      else                hs_cnt_n = hs_cnt - 4'd1;
    end

    if (new_row_n && row_n == reg_vsp) begin
      vsync_n  = 1'b1;
      vs_cnt_n = reg_vsw - 4'd1;
    end else if (line_adv && bus.vsync) begin
      if (vs_cnt == 4'd0) vsync_n = 1'b0;
      else                vs_cnt_n = vs_cnt - 4'd1;
    end

    new_col_n  = (dot_n == 4'd0);
    end_col_n  = (dot_n >= reg_cth);
    new_line_n = new_col_n && (col_n == 8'd0);

    if (!frame_start)    new_frame_n = 2'b00;
    else if (reg_im[0])  new_frame_n = field_n ? 2'b01 : 2'b10;
    else                 new_frame_n = 2'b11;

    visible_n[0] = (state_n == V_ACTIVE) && (row_n < reg_vd);
    visible_n[1] = visible_n[0] && (col_n < reg_hd);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= V_ACTIVE;
      dot          <= '0;
      field        <= FIELD_INIT;
      started      <= 1'b0;
      hs_cnt       <= '0;
      vs_cnt       <= '0;
      bus.col      <= '0;
      bus.line     <= '0;
      bus.row      <= '0;
      bus.newCol   <= 1'b0;
      bus.endCol   <= 1'b0;
      bus.newLine  <= 1'b0;
      bus.newRow   <= 1'b0;
      bus.newFrame <= 2'b00;
      bus.visible  <= 2'b00;
      bus.hsync    <= 1'b0;
      bus.vsync    <= 1'b0;
    end else if (enable) begin
      state        <= state_n;
      dot          <= dot_n;
      field        <= field_n;
      started      <= started_n;
      hs_cnt       <= hs_cnt_n;
      vs_cnt       <= vs_cnt_n;
      bus.col      <= col_n;
      bus.line     <= line_n;
      bus.row      <= row_n;
      bus.newCol   <= new_col_n;
      bus.endCol   <= end_col_n;
      bus.newLine  <= new_line_n;
      bus.newRow   <= new_row_n;
      bus.newFrame <= new_frame_n;
      bus.visible  <= visible_n;
      bus.hsync    <= hsync_n;
      bus.vsync    <= vsync_n;
    end
  end

endmodule

// File: tb/tb_vdc_video_timing.sv
// Bench for vdc_video_timing: arithmetic raster model checked every cycle,
// plus directed literal checks at hand-computed dot positions.
module tb_vdc_video_timing;
  localparam bit FI = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] reg_ht = 8'd9, reg_hd = 8'd8, reg_hsp = 8'd5;
  logic [3:0] reg_hsw = 4'd2, reg_vsw = 4'd2;
  logic [7:0] reg_vt = 8'd3, reg_vd = 8'd2, reg_vsp = 8'd1;
  logic [4:0] reg_va = 5'd0, reg_ctv = 5'd7;
  logic [1:0] reg_im = 2'b00;
  logic [3:0] reg_cth = 4'd7;

  int  pass_cnt = 0;
  int  chk_cnt  = 0;
  int  n_en     = 0;
  int  en_ph    = 0;
  bit  model_on = 1'b0;

  vdc_video_timing_if bus ();

  vdc_video_timing #(.FIELD_INIT(FI)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .reg_ht(reg_ht), .reg_hd(reg_hd), .reg_hsp(reg_hsp), .reg_hsw(reg_hsw),
    .reg_vsw(reg_vsw), .reg_vt(reg_vt), .reg_va(reg_va), .reg_vd(reg_vd),
    .reg_vsp(reg_vsp), .reg_im(reg_im), .reg_ctv(reg_ctv), .reg_cth(reg_cth),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  logic [30:0] dut_vec;
  assign dut_vec = {bus.col, bus.line, bus.row, bus.newCol, bus.endCol, bus.newLine,
                    bus.newRow, bus.newFrame, bus.visible, bus.hsync, bus.vsync};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, n_en - 1);
  endtask

  // Position from the global dot index t, assuming registers constant since restart.
  function automatic logic [30:0] model(input int t);
    int dpc, cpl, lpr, act, fl, dot, cg, c, lg, f, lf, r, l, k, d, e0, hw, vw;
    bit in_act, nc, ec, nl, nr, v0, v1, hs, vs;
    logic [1:0] nf;
    dpc = reg_cth + 1;  cpl = reg_ht + 1;  lpr = reg_ctv + 1;
    act = (reg_vt + 1) * lpr;  fl = act + reg_va;
    dot = t % dpc;  cg = t / dpc;  c = cg % cpl;
    lg = cg / cpl;  f = lg / fl;  lf = lg % fl;
    in_act = (lf < act);
    if (in_act) begin r = lf / lpr; l = lf % lpr; end
    else begin r = (reg_vt + 1) % 256; l = lf - act; end
    nc = (dot == 0);
    ec = (dot == reg_cth);
    nl = nc && (c == 0);
    nr = nl && in_act && (l == 0);
    if (!(nr && r == 0)) nf = 2'b00;
    else if (reg_im[0])  nf = ((FI ? 1 : 0) ^ (f % 2)) != 0 ? 2'b01 : 2'b10;
    else                 nf = 2'b11;
    v0 = in_act && (r < reg_vd);
    v1 = v0 && (c < reg_hd);
    hw = (reg_hsw == 0) ? 16 : reg_hsw;
    vw = (reg_vsw == 0) ? 16 : reg_vsw;
    hs = 1'b0;
    if (reg_hsp < cpl) begin
      k  = (c - reg_hsp + cpl) % cpl;
      hs = (cg >= k) && (k < hw);
    end
    vs = 1'b0;
    if (reg_vsp <= reg_vt) begin
      e0 = reg_vsp * lpr;
      d  = (lf - e0 + fl) % fl;
      vs = (lg >= d) && (d < vw);
    end
    return {8'(c), 5'(l), 8'(r), nc, ec, nl, nr, nf, v1, v0, hs, vs};
  endfunction

  always @(posedge clk) begin
    if (reset)       n_en <= 0;
    else if (enable) n_en <= n_en + 1;
  end

  always @(negedge clk) begin
    if (model_on)
      check("bus", 32'(dut_vec), (n_en == 0) ? 32'd0 : 32'(model(n_en - 1)));
  end

  // Issues n enables with one idle cycle after every two, so outputs must hold.
  task automatic run(input int n);
    int k = 0;
    while (k < n) begin
      en_ph++;
      if (en_ph % 3 == 2) enable = 1'b0;
      else begin enable = 1'b1; k++; end
      @(posedge clk); #1;
    end
    enable = 1'b0;
  endtask

  task automatic restart();
    model_on = 1'b0;
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_on = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    // Phase 1: 80 dots/line, 8 lines/row, 4 rows, no adjust, non-interlaced.
    restart();
    check("p1_reset_newRow", bus.newRow, 1'b0);
    run(1);
    check("p1_t0_newFrame", bus.newFrame, 2'b11);
    check("p1_t0_newRow", bus.newRow, 1'b1);
    run(7);
    check("p1_t7_endCol", {bus.newCol, bus.endCol}, 2'b01);
    run(1);
    check("p1_t8_col", bus.col, 8'd1);
    check("p1_t8_newCol", bus.newCol, 1'b1);
    run(32);
    check("p1_t40_hsync", bus.hsync, 1'b1);
    run(16);
    check("p1_t56_hsync", bus.hsync, 1'b0);
    run(8);
    check("p1_t64_visible", bus.visible, 2'b01);
    run(16);
    check("p1_t80_line", bus.line, 5'd1);
    check("p1_t80_newLine", bus.newLine, 1'b1);
    check("p1_t80_visible", bus.visible, 2'b11);
    run(560);
    check("p1_t640_row", bus.row, 8'd1);
    check("p1_t640_newRow", bus.newRow, 1'b1);
    check("p1_t640_vsync", bus.vsync, 1'b1);
    run(160);
    check("p1_t800_vsync", bus.vsync, 1'b0);
    run(480);
    check("p1_t1280_visible", bus.visible, 2'b00);
    run(1280);
    check("p1_t2560_row", bus.row, 8'd0);
    check("p1_t2560_newFrame", bus.newFrame, 2'b11);
    run(2800);

    // Phase 2: 3 adjust lines, interlaced fields.
    model_on = 1'b0;
    reg_cth = 4'd1; reg_va = 5'd3; reg_im = 2'b01; reg_hsw = 4'd3; reg_vsw = 4'd0;
    restart();
    run(1);
    check("p2_t0_newFrame", bus.newFrame, 2'b10);
    run(640);
    check("p2_t640_row", bus.row, 8'd4);
    check("p2_t640_adjust", {bus.newLine, bus.newRow, bus.visible}, 4'b1000);
    run(40);
    check("p2_t680_line", bus.line, 5'd2);
    run(20);
    check("p2_t700_pos", {bus.row, bus.line}, 13'd0);
    check("p2_t700_newFrame", bus.newFrame, 2'b01);
    run(700);
    check("p2_t1400_newFrame", bus.newFrame, 2'b10);
    run(700);

    // Phase 3: one dot per column, 16-column hsync, vsync spanning frame wrap.
    model_on = 1'b0;
    reg_cth = 4'd0; reg_ht = 8'd30; reg_hsp = 8'd5; reg_hsw = 4'd0;
    reg_ctv = 5'd1; reg_vt = 8'd2; reg_va = 5'd0; reg_vd = 8'd3;
    reg_vsp = 8'd2; reg_vsw = 4'd3; reg_im = 2'b00;
    restart();
    run(1);
    run(4);
    check("p3_t4_hsync", bus.hsync, 1'b0);
    run(1);
    check("p3_t5_hsync", bus.hsync, 1'b1);
    check("p3_t5_colstrobes", {bus.newCol, bus.endCol}, 2'b11);
    run(15);
    check("p3_t20_hsync", bus.hsync, 1'b1);
    run(1);
    check("p3_t21_hsync", bus.hsync, 1'b0);
    run(165);
    check("p3_t186_vsync", bus.vsync, 1'b1);
    run(31);
    check("p3_t217_vsync", bus.vsync, 1'b0);
    run(400);

    // Phase 4: reset mid-row, then shrink reg_ht below the current column.
    model_on = 1'b0;
    reg_ht = 8'd20; reg_hd = 8'd8; reg_ctv = 5'd1; reg_vt = 8'd3;
    reg_vd = 8'd2; reg_hsp = 8'd5; reg_hsw = 4'd2; reg_vsp = 8'd1; reg_vsw = 4'd2;
    restart();
    run(89);
    check("p4_mid_pos", {bus.row, bus.col}, {8'd2, 8'd4});
    restart();
    run(1);
    check("p4_restart_pos", {bus.col, bus.line, bus.row}, 21'd0);
    check("p4_restart_newFrame", bus.newFrame, 2'b11);
    run(10);
    check("p4_t10_col", bus.col, 8'd10);
    model_on = 1'b0;
    reg_ht = 8'd3;
    run(1);
    check("p4_shrink_col", bus.col, 8'd0);
    check("p4_shrink_line", {bus.line, bus.newLine}, {5'd1, 1'b1});
    run(1);
    check("p4_shrink_next", bus.col, 8'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
